ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 136 +++++++++++++
 tb/tb_ex_muldiv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring divider.
// Both work on operand magnitudes, retire one bit per cycle, and apply the sign on commit.
// MTHI/MTLO write HI/LO directly, and only while the unit is idle.
module ex_muldiv #(
    parameter int CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            is_div;
    logic            div_zero;
    logic            neg_q;
    logic            neg_r;
    logic [31:0]     a_raw;
    logic [31:0]     b_mag;
    logic [63:0]     prod;
    logic [32:0]     rem;

    logic            signed_op;
    logic [31:0]     a_mag_in;
    logic [31:0]     b_mag_in;
    logic [32:0]     mul_sum;
    logic [33:0]     div_diff;
    logic [32:0]     div_shift;
    logic [63:0]     next_prod;
    logic [32:0]     next_rem;
    logic [63:0]     mul_res;
    logic [31:0]     quo;
    logic [31:0]     rmd;

    // Operand magnitudes at accept time, one iteration step, and the sign-corrected final results
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_mag_in  = (signed_op && a[31]) ? -a : a;
        b_mag_in  = (signed_op && b[31]) ? -b : b;
        mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, b_mag} : 33'd0);
        div_diff  = {rem, prod[31]} - {2'b00, b_mag};
        div_shift = {rem[31:0], prod[31]};
        next_prod = is_div ? {prod[62:0], ~div_diff[33]} : {mul_sum, prod[31:1]};
        next_rem  = rem;
        if (is_div)
            next_rem = div_diff[33] ? div_shift : div_diff[32:0];
        mul_res   = neg_q ? -next_prod : next_prod;
        quo       = neg_q ? -next_prod[31:0] : next_prod[31:0];
        rmd       = neg_r ? -next_rem[31:0] : next_rem[31:0];
    end

    // Control FSM: accept ops in IDLE, iterate in RUN, commit HI/LO on the final RUN edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            count    <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            a_raw    <= 32'd0;
            b_mag    <= 32'd0;
            prod     <= 64'd0;
            rem      <= 33'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state    <= RUN;
                                busy     <= 1'b1;
                                count    <= '0;
                                is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                                div_zero <= (b == 32'd0);
                                neg_q    <= signed_op && (a[31] ^ b[31]);
                                neg_r    <= signed_op && a[31];
                                a_raw    <= a;
                                b_mag    <= b_mag_in;
                                prod     <= {32'd0, a_mag_in};
                                rem      <= 33'd0;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    prod  <= next_prod;
                    rem   <= next_rem;
                    count <= count + CW'(1);
                    if (count == CW'(CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!is_div) begin
                            hi <= mul_res[63:32];
                            lo <= mul_res[31:0];
                        end else if (div_zero) begin
                            hi <= a_raw;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= rmd;
                            lo <= quo;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random ops against an arithmetic model.
module tb_ex_muldiv;

    localparam int CYCLES = 32;
    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] MULT  = 3'b001;
    localparam logic [2:0] MULTU = 3'b010;
    localparam logic [2:0] DIV   = 3'b011;
    localparam logic [2:0] DIVU  = 3'b100;
    localparam logic [2:0] MTHI  = 3'b101;
    localparam logic [2:0] MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    ex_muldiv #(.CYCLES(CYCLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // Architectural model of HI/LO, written from the instruction semantics
    task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        case (o)
            MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {exp_hi, exp_lo} = sp;
            end
            MULTU: begin
                up = {32'd0, x} * {32'd0, y};
                {exp_hi, exp_lo} = up;
            end
            DIV: begin
                if (y == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    exp_lo = 32'h8000_0000;
                    exp_hi = 32'd0;
                end else begin
                    exp_lo = $signed(x) / $signed(y);
                    exp_hi = $signed(x) % $signed(y);
                end
            end
            DIVU: begin
                if (y == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = x;
                end else begin
                    exp_lo = x / y;
                    exp_hi = x % y;
                end
            end
            MTHI: exp_hi = x;
            MTLO: exp_lo = x;
            default: ;
        endcase
    endtask

    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Issue an iterative op and follow it through RUN to commit.
    // A new request can be injected at RUN cycle inj_at and is left asserted on return.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inj_at, input logic [2:0] io, input logic [31:0] ix, input logic [31:0] iy);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = exp_hi;
        old_lo = exp_lo;
        apply_stimulus(o, x, y);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output({tag, " busy_start"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i < CYCLES; i++) begin
            @(posedge clk);
            #1;
            check_output({tag, " busy_run"}, {31'd0, busy}, 32'd1);
            check_output({tag, " hi_hold"}, hi, old_hi);
            check_output({tag, " lo_hold"}, lo, old_lo);
            if (i == inj_at) begin
                start = 1'b1;
                op    = io;
                a     = ix;
                b     = iy;
            end
        end
        model_op(o, x, y);
        @(posedge clk);
        #1;
        check_output({tag, " busy_done"}, {31'd0, busy}, 32'd0);
        check_output({tag, " hi"}, hi, exp_hi);
        check_output({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [2:0]  ops [4];
        ops = '{MULT, MULTU, DIV, DIVU};

        // Reset wins over a simultaneous MTHI request
        rst   = 1'b1;
        start = 1'b1;
        op    = MTHI;
        a     = 32'hDEAD_BEEF;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset busy", {31'd0, busy}, 32'd0);
        check_output("reset hi", hi, 32'd0);
        check_output("reset lo", lo, 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        // Directed arithmetic corners
        run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, -1, NOP, 32'd0, 32'd0);
        check_output("mult_neg hi_const", exp_hi, 32'hFFFF_FFFF);
        check_output("mult_neg lo_const", exp_lo, 32'hFFFF_FFEB);
        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, NOP, 32'd0, 32'd0);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, -1, NOP, 32'd0, 32'd0);
        run_op("divu_zero", DIVU, 32'd7, 32'd0, -1, NOP, 32'd0, 32'd0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, NOP, 32'd0, 32'd0);
        run_op("div_zero_s", DIV, 32'hFFFF_FFF0, 32'd0, -1, NOP, 32'd0, 32'd0);

        // MTHI in IDLE takes effect on the next edge without raising busy
        apply_stimulus(MTHI, 32'h1234_5678, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        model_op(MTHI, 32'h1234_5678, 32'd0);
        check_output("mthi hi", hi, exp_hi);
        check_output("mthi lo", lo, exp_lo);
        check_output("mthi busy", {31'd0, busy}, 32'd0);

        // Undefined op codes change nothing
        apply_stimulus(3'b111, 32'hAAAA_5555, 32'h1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("undef busy", {31'd0, busy}, 32'd0);
        check_output("undef hi", hi, exp_hi);
        check_output("undef lo", lo, exp_lo);

        // MTLO raised mid-RUN is held off, then accepted in the cycle busy falls
        run_op("mtlo_stall", MULTU, 32'h0001_0003, 32'h0000_0100, 5, MTLO, 32'hCAFE_F00D, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        model_op(MTLO, 32'hCAFE_F00D, 32'd0);
        check_output("mtlo_late lo", lo, exp_lo);
        check_output("mtlo_late hi", hi, exp_hi);
        check_output("mtlo_late busy", {31'd0, busy}, 32'd0);

        // Back-to-back MULTU: the second request is pending and is accepted right after commit
        run_op("b2b_first", MULTU, 32'h89AB_CDEF, 32'h0000_0011, 1, MULTU, 32'h7654_3210, 32'h0123_4567);
        run_op("b2b_second", MULTU, 32'h7654_3210, 32'h0123_4567, -1, NOP, 32'd0, 32'd0);

        // Reset in the middle of a DIV aborts it without committing
        apply_stimulus(DIV, 32'h7FFF_0001, 32'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check_output("abort busy", {31'd0, busy}, 32'd0);
        check_output("abort hi", hi, exp_hi);
        check_output("abort lo", lo, exp_lo);
        run_op("after_abort", MULT, 32'hFFFF_FF00, 32'hFFFF_FFFE, -1, NOP, 32'd0, 32'd0);

        // Random ops against the model, including occasional tiny or zero divisors
        for (int k = 0; k < 10; k++) begin
            rop = ops[$urandom_range(0, 3)];
            rx  = $urandom;
            ry  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
            if ($urandom_range(0, 1) == 1)
                ry = ry >> $urandom_range(0, 31);
            run_op("random", rop, rx, ry, -1, NOP, 32'd0, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
